ifetch: RTL
===========

# ifetch

Instruction fetch and prefetch queue for the 16-bit compressed-ISA core. It reads aligned 32-bit words from the instruction bus and splits each word into 16-bit halfwords. It buffers the halfwords in a small queue and hands them, one per cycle, to the decoder as `ins` qualified by `rdone`. Branch and jump redirects from execute flush the queue and restart fetch at the new PC.

## Interface
- `RV`, 32: register and PC width.
- `QD`, 4: queue depth in halfwords; power of two, at least 2.
- `RESET_PC`, 0: fetch PC loaded on reset; bit 0 is ignored.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ready_in`  in  1  downstream accepts one instruction this cycle.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  RV  new fetch PC; bit 0 is ignored.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  RV  word-aligned read address; bits [1:0] = 0.
- `mem_ack`  in  1  read complete; `mem_rdata` and `mem_fault` are valid.
- `mem_rdata`  in  32  read data, little-endian.
- `mem_fault`  in  1  bus error on this read.
- `ins`  out  16  instruction at the queue head; 0 when the queue is empty.
- `rdone`  out  1  `ins` is valid and consumed this cycle.
- `ins_pc`  out  RV  byte address of `ins`.
- `ifault`  out  1  the head entry is a fetch fault.

## Operation
- State:
  - fetch PC `fpc`, halfword aligned.
  - circular queue of QD entries, each {ins, pc, fault}.
  - head and tail pointers with a count.
  - `busy`: a request is outstanding.
  - `drop`: discard the outstanding response.
  - `halted`: fetch is stopped after a fault.
- Issue rule:
  - `mem_req` rises when `!busy & !halted`, `redirect` is low, and the queue has enough free entries.
  - Free entries needed: 2 if `fpc[1]==0`, otherwise 1.
  - `mem_addr = {fpc[RV-1:2],2'b00}`.
  - `mem_req` and `mem_addr` are held stable until `mem_ack`. Only one request is outstanding at a time.
- Response with `drop==0` and no fault:
  - If `fpc[1]==0`, push `rdata[15:0]` at pc=`fpc`, then `rdata[31:16]` at pc=`fpc+2`, and set `fpc += 4`.
  - If `fpc[1]==1`, push only `rdata[31:16]` and set `fpc += 2`.
- Response with `mem_fault==1`:
  - Push one entry {ins=0, pc=fpc, fault=1} and set `halted`.
  - `ins=0` decodes as a trap downstream.
- Consume:
  - `rdone = count!=0 & ready_in & !redirect`. Pops the head.
  - `ins`, `ins_pc` and `ifault` are combinational from the head entry.
- Redirect:
  - Empty the queue and clear `halted`.
  - Set `fpc = {redirect_pc[RV-1:1],1'b0}`.
  - If `busy` and `mem_ack` is low, set `drop`. The response is discarded when it arrives, then `drop` clears.
- PC arithmetic is modulo 2^RV; wrap-around is silent.

## Timing
- Reset values:
  - `mem_req`, `rdone`, `ifault` = 0; `ins` = 0; `ins_pc` = 0.
  - Queue empty; `busy`, `drop`, `halted` = 0; `fpc` = `RESET_PC`.
- First `mem_req` is in the first cycle after `reset` deasserts.
- Latency, with `mem_ack` one cycle after the request cycle:
  - Without bypass, `rdone` is asserted at the earliest one cycle after `mem_ack`.
  - Sustained throughput is 1 instruction per cycle while the queue is non-empty.
- Simultaneous events:
  - Push and pop in the same cycle: legal. Count changes by the net amount, and a full queue accepts a push if a pop frees space that cycle.
  - `redirect` with `mem_ack` in the same cycle: the response is discarded, `drop` is not set, and a new request is issued the next cycle.
  - `redirect` with `ready_in` in the same cycle: redirect wins and `rdone` = 0.
  - Full queue: `mem_req` stays low.
  - Empty queue: `rdone` = 0 and `ins` = 0.
- Asserting `reset` mid-transaction drops all state immediately. The bus owner must also abandon the request.

## Configuration
- `IFETCH_BYPASS_EN`:
  - When defined, and the queue is empty and `ready_in` is high, the first halfword of an acknowledged response is presented on `ins` and `rdone` in the `mem_ack` cycle itself. That halfword is not written to the queue; the second halfword is queued.
  - Fault responses bypass the same way, with `ifault` = 1.
  - When not defined, all data passes through the queue, giving a 1-cycle extra latency.

## Test plan
- Reset release with `RESET_PC`=0 and `mem_rdata`=0x22223333 acked in cycle 2, `ready_in`=1 -> `mem_addr`=0; outputs `ins`=0x3333 at pc 0, then 0x2222 at pc 2, on consecutive `rdone` cycles.
- Redirect to 0x102 -> `mem_addr`=0x100; only the upper halfword is delivered, with `ins_pc`=0x102, then fetch continues at 0x104.
- `ready_in`=0 held with QD=4 -> after two acked words, `mem_req` stays low; no `rdone`.
- Redirect while a request is outstanding, with the ack arriving 3 cycles later -> the old data is never delivered; the next `mem_addr` equals the new target.
- `mem_fault`=1 at address 0x40 -> one `rdone` with `ifault`=1, `ins`=0, `ins_pc`=0x40; no further `mem_req` until a redirect.
- With `IFETCH_BYPASS_EN`, empty queue and `ready_in`=1 -> `rdone` is asserted in the same cycle as `mem_ack`; without the macro, one cycle later.

Source files
------------

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch and prefetch queue for the 16-bit compressed-ISA
// core.
//
// Reads aligned 32-bit words from the instruction bus and splits each word
// into 16-bit halfwords. The halfwords are buffered in a QD-entry circular
// queue and handed to the decoder one per cycle. A redirect from execute
// flushes the queue and restarts fetch at the new PC.
//
// Parameters:
//   RV        register / PC width
//   QD        queue depth in halfwords (power of two, >= 2)
//   RESET_PC  fetch PC after reset (bit 0 ignored)
//
// Optional build macro:
//   IFETCH_BYPASS_EN  when defined, the first halfword of a response is handed
//                     straight to the decoder in the mem_ack cycle if the
//                     queue is empty and ready_in is high.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   ready_in     in   decoder accepts one instruction this cycle
//   redirect     in   flush queue, restart fetch at redirect_pc
//   redirect_pc  in   new fetch PC (bit 0 ignored)
//   mem_req      out  read request, held until mem_ack
//   mem_addr     out  word-aligned read address, held until mem_ack
//   mem_ack      in   read complete; mem_rdata / mem_fault valid
//   mem_rdata    in   read data, little-endian
//   mem_fault    in   bus error on this read
//   ins          out  instruction at queue head, 0 when empty
//   rdone        out  ins valid and consumed this cycle
//   ins_pc       out  byte address of ins
//   ifault       out  head entry is a fetch fault
//
// Handshakes: a request is outstanding from the first cycle mem_req is high
// until the cycle mem_ack is high; mem_req/mem_addr do not change in between,
// and mem_ack is only meaningful while mem_req is high. On the decoder side
// ins/ins_pc/ifault are valid whenever the queue is non-empty, and the head
// is consumed exactly in the cycles where rdone is high.
// ----------------------------------------------------------------------------
module ifetch #(
  parameter int             RV       = 32,
  parameter int             QD       = 4,
  parameter logic [RV-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready_in,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  output logic          mem_req,
  output logic [RV-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_fault,
  output logic [15:0]   ins,
  output logic          rdone,
  output logic [RV-1:0] ins_pc,
  output logic          ifault
);

  localparam int AW = (QD > 2) ? $clog2(QD) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QD_C = CW'(QD);

  // Fetch control: IDLE (free to issue), BUSY (request outstanding),
  // DROP (request outstanding, response to be discarded), HALT (stopped
  // after a fault until the next redirect).
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP, S_HALT} state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [RV-1:0] r_fpc;
  logic [RV-1:0] w_fpc_n;
  logic [RV-1:0] r_addr;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW-1:0] w_tail1;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;

  logic [15:0]   r_q_ins [QD];
  logic [RV-1:0] r_q_pc  [QD];
  logic          r_q_flt [QD];

  logic          w_busy;
  logic          w_rsp;
  logic          w_take;
  logic          w_empty;
  logic          w_pop;
  logic          w_byp;
  logic          w_halt_n;
  logic          w_free_ok;
  logic          w_issue;
  logic [1:0]    w_nh;
  logic [1:0]    w_npush;
  logic [15:0]   w_h0_ins;
  logic [RV-1:0] w_h0_pc;
  logic          w_h0_flt;
  logic [15:0]   w_h1_ins;
  logic [RV-1:0] w_h1_pc;
  logic [15:0]   w_w0_ins;
  logic [RV-1:0] w_w0_pc;
  logic          w_w0_flt;
  logic          w_unused;

  assign w_unused = redirect_pc[0];

  assign w_busy  = (r_state == S_BUSY) || (r_state == S_DROP);
  assign w_rsp   = w_busy & mem_ack;
  // A response is used only in BUSY and only if no redirect coincides.
  assign w_take  = (r_state == S_BUSY) & mem_ack & ~redirect;
  assign w_empty = (r_cnt == '0);
  assign w_pop   = ~w_empty & ready_in & ~redirect;

`ifdef IFETCH_BYPASS_EN
  assign w_byp = w_take & w_empty & ready_in;
`else
  assign w_byp = 1'b0;
`endif

  // Halfwords carried by this response: h0 is the first in program order,
  // h1 only exists for a non-faulting read at a word-aligned fpc.
  always_comb begin
    w_h0_ins = mem_fault ? 16'h0000 : (r_fpc[1] ? mem_rdata[31:16] : mem_rdata[15:0]);
    w_h0_pc  = r_fpc;
    w_h0_flt = mem_fault;
    w_h1_ins = mem_rdata[31:16];
    w_h1_pc  = r_fpc + RV'(2);
    w_nh     = 2'd0;
    if (w_take) begin
      w_nh = (mem_fault || r_fpc[1]) ? 2'd1 : 2'd2;
    end
  end

  // When h0 bypasses the queue, h1 (if any) becomes the first write.
  assign w_npush  = w_nh - {1'b0, w_byp};
  assign w_w0_ins = w_byp ? w_h1_ins : w_h0_ins;
  assign w_w0_pc  = w_byp ? w_h1_pc  : w_h0_pc;
  assign w_w0_flt = w_byp ? 1'b0     : w_h0_flt;
  assign w_tail1  = r_tail + AW'(1);

  assign w_cnt_n = redirect ? '0 : (r_cnt + CW'(w_npush) - CW'(w_pop));

  always_comb begin
    w_fpc_n = r_fpc;
    if (redirect) begin
      w_fpc_n = {redirect_pc[RV-1:1], 1'b0};
    end else if (w_take && !mem_fault) begin
      w_fpc_n = r_fpc + (r_fpc[1] ? RV'(2) : RV'(4));
    end
  end

  assign w_halt_n = (w_take & mem_fault) | ((r_state == S_HALT) & ~redirect);

  // Space is judged on next-cycle occupancy; since only one request is ever
  // outstanding and pops only free space, the response always fits.
  assign w_free_ok = (QD_C - w_cnt_n) >= (w_fpc_n[1] ? CW'(1) : CW'(2));
  assign w_issue   = ~redirect & ((r_state == S_IDLE) | w_rsp) & ~w_halt_n & w_free_ok;

  always_comb begin
    w_state_n = r_state;
    if (redirect) begin
      w_state_n = (w_busy && !mem_ack) ? S_DROP : S_IDLE;
    end else if (w_issue) begin
      w_state_n = S_BUSY;
    end else if (w_halt_n) begin
      w_state_n = S_HALT;
    end else if (w_rsp) begin
      w_state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_fpc   <= {RESET_PC[RV-1:1], 1'b0};
      r_addr  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_fpc   <= w_fpc_n;
      r_cnt   <= w_cnt_n;
      if (w_issue) begin
        r_addr <= {w_fpc_n[RV-1:2], 2'b00};
      end
      if (redirect) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        r_head <= r_head + AW'(w_pop);
        r_tail <= r_tail + AW'(w_npush);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_npush != 2'd0) begin
      r_q_ins[r_tail] <= w_w0_ins;
      r_q_pc[r_tail]  <= w_w0_pc;
      r_q_flt[r_tail] <= w_w0_flt;
    end
    if (w_npush == 2'd2) begin
      r_q_ins[w_tail1] <= w_h1_ins;
      r_q_pc[w_tail1]  <= w_h1_pc;
      r_q_flt[w_tail1] <= 1'b0;
    end
  end

  assign mem_req  = w_busy;
  assign mem_addr = r_addr;
  assign rdone    = w_pop | w_byp;

  always_comb begin
    ins    = 16'h0000;
    ins_pc = '0;
    ifault = 1'b0;
    if (!w_empty) begin
      ins    = r_q_ins[r_head];
      ins_pc = r_q_pc[r_head];
      ifault = r_q_flt[r_head];
    end else if (w_byp) begin
      ins    = w_h0_ins;
      ins_pc = w_h0_pc;
      ifault = w_h0_flt;
    end
  end

endmodule
